// File: rtl/pc_branch_unit_pkg.sv
// rtl/pc_branch_unit_pkg.sv - shared defaults and next-PC select encoding for the fetch PC unit
package pc_branch_unit_pkg;

  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_RESET_PC = 0;
  localparam int DEFAULT_RAS_DEPTH = 4;

  localparam logic [2:0] SEL_SEQ  = 3'd0;
  localparam logic [2:0] SEL_BR   = 3'd1;
  localparam logic [2:0] SEL_JMP  = 3'd2;
  localparam logic [2:0] SEL_CALL = 3'd3;
  localparam logic [2:0] SEL_RET  = 3'd4;

endpackage

// File: rtl/pc_branch_unit_ras.sv
// rtl/pc_branch_unit_ras.sv - circular return-address stack with push/pop/swap and sticky flags
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               push_data,
  output logic [WIDTH-1:0]               top_data,
  output logic                           empty,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH+1);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d, top_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             full;

  // sp points at the next free slot; when full it also points at the oldest entry
  assign top_idx  = sp_q - 1'b1;
  assign full     = (cnt_q == CNT_W'(RAS_DEPTH));
  assign empty    = (cnt_q == '0);
  assign top_data = mem_q[top_idx];
  assign count    = cnt_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (en) begin
      if (pop && !empty) begin
        if (push) begin
          mem_d[top_idx] = push_data;
        end else begin
          sp_d  = top_idx;
          cnt_d = cnt_q - 1'b1;
        end
      end else begin
        if (pop) unf_d = 1'b1;
        if (push) begin
          mem_d[sp_q] = push_data;
          sp_d        = sp_q + 1'b1;
          if (full) ovf_d = 1'b1;
          else      cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - fetch-stage program counter with branch/jump/call/return selection
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               RAS_DEPTH = DEFAULT_RAS_DEPTH,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           branch_taken,
  input  logic                           jump,
  input  logic                           call,
  input  logic                           ret,
  input  logic [WIDTH-1:0]               sign_imm,
  input  logic [WIDTH-1:0]               jump_target,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc_plus1,
  output logic [WIDTH-1:0]               pc_branch,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic [2:0]       sel;

  assign pc        = pc_q;
  assign pc_plus1  = pc_q + 1'b1;
  assign pc_branch = pc_plus1 + sign_imm;

  // A ret against an empty stack is dropped so lower-priority requests decide
  always_comb begin
    sel = SEL_SEQ;
    if (ret && !ras_empty) sel = SEL_RET;
    else if (call)         sel = SEL_CALL;
    else if (jump)         sel = SEL_JMP;
    else if (branch_taken) sel = SEL_BR;
  end

  always_comb begin
    pc_d = pc_q;
    if (!stall) begin
      case (sel)
        SEL_RET:           pc_d = ras_top;
        SEL_CALL, SEL_JMP: pc_d = jump_target;
        SEL_BR:            pc_d = pc_branch;
        default:           pc_d = pc_plus1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  ras_stack #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (reset),
    .en       (!stall),
    .push     (call),
    .pop      (ret),
    .push_data(pc_plus1),
    .top_data (ras_top),
    .empty    (ras_empty),
    .count    (ras_count),
    .overflow (ras_overflow),
    .underflow(ras_underflow)
  );

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - self-checking bench for pc_branch_unit against a queue-based reference model
module tb_pc_branch_unit;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic [W-1:0] sign_imm = '0, jump_target = '0;
  logic [W-1:0] pc, pc_plus1, pc_branch;
  logic [2:0]   ras_count;
  logic         ras_overflow, ras_underflow;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_pc;
  logic [W-1:0] m_q[$];
  logic         m_ovf, m_unf;

  pc_branch_unit #(.WIDTH(W), .RAS_DEPTH(D), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .jump(jump), .call(call), .ret(ret), .sign_imm(sign_imm), .jump_target(jump_target),
    .pc(pc), .pc_plus1(pc_plus1), .pc_branch(pc_branch), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("pc", pc, m_pc);
    chk("ras_count", W'(ras_count), W'(m_q.size()));
    chk("ras_overflow", W'(ras_overflow), W'(m_ovf));
    chk("ras_underflow", W'(ras_underflow), W'(m_unf));
  endtask

  task automatic model_reset();
    m_pc = '0;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Reference behaviour: the stack is an ordered list of return addresses, oldest first
  task automatic model_step();
    logic [W-1:0] nxt;
    if (stall) return;
    nxt = m_pc + 1;
    if (ret && m_q.size() > 0) begin
      nxt = m_q[m_q.size()-1];
      if (call) m_q[m_q.size()-1] = m_pc + 1;
      else void'(m_q.pop_back());
    end else begin
      if (ret) m_unf = 1'b1;
      if (call) begin
        m_q.push_back(m_pc + 1);
        if (m_q.size() > D) begin
          void'(m_q.pop_front());
          m_ovf = 1'b1;
        end
        nxt = jump_target;
      end else if (jump) begin
        nxt = jump_target;
      end else if (branch_taken) begin
        nxt = m_pc + 1 + sign_imm;
      end
    end
    m_pc = nxt;
  endtask

  task automatic cyc(input bit c, input bit r, input bit j, input bit b, input bit s,
                     input logic [W-1:0] imm, input logic [W-1:0] jt);
    call = c; ret = r; jump = j; branch_taken = b; stall = s;
    sign_imm = imm; jump_target = jt;
    #1;
    chk("pc_plus1", pc_plus1, m_pc + 1);
    chk("pc_branch", pc_branch, m_pc + 1 + imm);
    model_step();
    @(posedge clk);
    #2;
    chk_state();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk_state();
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ret_pcs [4];
    ret_pcs[0] = 41; ret_pcs[1] = 31; ret_pcs[2] = 21; ret_pcs[3] = 11;
    model_reset();

    #12;
    chk_state();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, '0, '0);
    chk("pc_idle3", pc, 3);
    chk("pc_plus1_at3", pc_plus1, 4);

    cyc(0, 0, 1, 0, 0, '0, 10);
    sign_imm = -5; branch_taken = 1'b1; jump = 1'b0;
    #1 chk("pc_branch_neg", pc_branch, 6);
    cyc(0, 0, 0, 1, 0, -5, '0);
    chk("pc_after_branch", pc, 6);

    cyc(0, 0, 1, 0, 0, '0, 32'hFFFF_FFFF);
    sign_imm = 1; jump = 1'b0;
    #1 chk("pc_branch_wrap", pc_branch, 1);
    chk("pc_plus1_wrap", pc_plus1, 0);

    cyc(0, 0, 1, 0, 0, '0, 20);
    cyc(1, 0, 0, 0, 0, '0, 100);
    chk("call_pc", pc, 100);
    chk("call_count", W'(ras_count), 1);
    cyc(0, 1, 0, 0, 0, '0, '0);
    chk("ret_pc", pc, 21);
    chk("ret_count", W'(ras_count), 0);

    cyc(0, 0, 1, 0, 0, '0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0, 0, '0, W'((k + 1) * 10));
    chk("nest_ovf", W'(ras_overflow), 1);
    chk("nest_count", W'(ras_count), 4);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 0, 0, 0, '0, '0);
      chk("nest_ret_pc", pc, ret_pcs[k]);
    end
    cyc(0, 1, 0, 0, 0, '0, '0);
    chk("nest_unf", W'(ras_underflow), 1);
    chk("nest_unf_pc", pc, 12);

    do_reset();
    cyc(1, 0, 0, 0, 0, '0, 300);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, '0, 500);
    chk("stall_pc", pc, 300);
    chk("stall_count", W'(ras_count), 1);
    do_reset();
    chk("async_rst_pc", pc, 0);
    chk("async_rst_count", W'(ras_count), 0);
    stall = 1'b0;

    cyc(0, 0, 1, 0, 0, '0, 54);
    cyc(1, 0, 0, 0, 0, '0, 70);
    cyc(1, 1, 0, 0, 0, '0, 200);
    chk("swap_pc", pc, 55);
    chk("swap_count", W'(ras_count), 1);
    cyc(0, 1, 0, 0, 0, '0, '0);
    chk("swap_top", pc, 71);
    cyc(0, 0, 1, 1, 0, 7, 123);
    chk("jump_over_branch", pc, 123);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63) == 0) do_reset();
      cyc(($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(4) == 0),
          ($urandom_range(3) == 0), ($urandom_range(7) == 0),
          W'($signed($urandom_range(64)) - 32), W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
